mem_arbiter_ctrl: RTL and testbench

MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

---
 rtl/mem_arbiter_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// Single-port RAM arbiter between the fetch (IF) and memory (MEM) stages.
// MEM has priority, but after MAX_MEM_STREAK back-to-back MEM grants while
// IF was waiting, IF gets the next slot. A BUSY access aborts with err=1
// once TIMEOUT cycles pass without ram_ready.
module mem_arbiter_ctrl #(
  parameter int unsigned MAX_MEM_STREAK = 4,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        if_done,
  output logic        mem_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int unsigned SW = (MAX_MEM_STREAK > 0) ? $clog2(MAX_MEM_STREAK + 1) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_grant_mem;
  logic          r_ram_we;
  logic [31:0]   r_ram_addr;
  logic [31:0]   r_ram_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [SW-1:0] r_streak;
  logic [CW-1:0] r_cnt;

  logic          w_req_any;
  logic          w_mem_win;
  logic          w_streak_full;
  logic          w_timeout;

  assign w_req_any     = if_req | mem_req;
  assign w_streak_full = (r_streak == SW'(MAX_MEM_STREAK));
  assign w_mem_win     = mem_req & ~(if_req & w_streak_full);
  assign w_timeout     = (r_cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: arbitrate in IDLE, leave BUSY on ready or timeout, DONE lasts one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next = S_BUSY;
      S_BUSY:  if (ram_ready || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant latch, streak tracking, BUSY counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_mem <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_streak    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_cnt       <= '0;
            r_grant_mem <= w_mem_win;
            if (w_mem_win) begin
              r_ram_addr  <= mem_addr;
              r_ram_we    <= mem_we;
              r_ram_wdata <= mem_wdata;
              if (!if_req)            r_streak <= '0;
              else if (!w_streak_full) r_streak <= r_streak + SW'(1);
            end else begin
              r_ram_addr  <= if_addr;
              r_ram_we    <= 1'b0;
              r_ram_wdata <= '0;
              r_streak    <= '0;
            end
          end
        end
        S_BUSY: begin
          if (ram_ready) begin
            r_rdata <= r_ram_we ? '0 : ram_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_en    = (r_state == S_BUSY);
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_done   = (r_state == S_DONE) & ~r_grant_mem;
  assign mem_done  = (r_state == S_DONE) &  r_grant_mem;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign stall_if  = if_req  & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: the driver issues transactions and
// pushes the predicted outcome; a negedge monitor checks RAM strobes and
// done pulses against the queue.
module tb_mem_arbiter_ctrl;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we, ram_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic        ram_en, ram_we, if_done, mem_done, err, stall_if, stall_mem;
  logic [31:0] ram_addr, ram_wdata, rdata;

  mem_arbiter_ctrl #(.MAX_MEM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .if_done(if_done), .mem_done(mem_done), .rdata(rdata), .err(err),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int unsigned busy;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned m_streak = 0;
  int unsigned mem_grants_in_row = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares RAM-side activity and done pulses against the scoreboard
  exp_t        m_e;
  int unsigned en_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      en_cnt     = 0;
      last_rdata = '0;
      last_err   = 1'b0;
    end else begin
      chk("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~if_done});
      chk("stall_mem", {31'd0, stall_mem}, {31'd0, mem_req & ~mem_done});
      if (ram_en) begin
        en_cnt++;
        if (q.size() == 0) chk("ram_en_unexpected", {31'd0, ram_en}, 32'd0);
        else begin
          chk("ram_addr", ram_addr, q[0].addr);
          chk("ram_we", {31'd0, ram_we}, {31'd0, q[0].we});
          chk("ram_wdata", ram_wdata, q[0].wdata);
        end
      end
      if (if_done || mem_done) begin
        chk("single_done", {31'd0, if_done & mem_done}, 32'd0);
        if (q.size() == 0) chk("done_unexpected", {31'd0, if_done | mem_done}, 32'd0);
        else begin
          m_e = q.pop_front();
          chk("done_owner_mem", {31'd0, mem_done}, {31'd0, m_e.is_mem});
          chk("rdata", rdata, m_e.rdata);
          chk("err", {31'd0, err}, {31'd0, m_e.err});
          chk("busy_cycles", en_cnt, m_e.busy);
          last_rdata = m_e.rdata;
          last_err   = m_e.err;
        end
        en_cnt = 0;
      end else begin
        chk("rdata_hold", rdata, last_rdata);
        chk("err_hold", {31'd0, err}, {31'd0, last_err});
      end
    end
  end

  // One transaction starting in IDLE. lat = BUSY cycle with ram_ready (0 = never).
  task automatic txn(input bit ir, input bit mr, input bit we,
                     input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                     input int unsigned lat, input bit drop, input logic [31:0] rd);
    exp_t e;
    bit   mw;
    bit   tmo;
    if_req = ir; mem_req = mr; mem_we = we;
    if_addr = ia; mem_addr = ma; mem_wdata = wd;
    if (!ir && !mr) begin
      repeat (2) @(posedge clk);
      #1;
      return;
    end
    // MEM priority with a fairness cap on consecutive MEM wins while IF waits
    mw = mr && !(ir && m_streak == MAXS);
    if (mw) m_streak = ir ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
    else    m_streak = 0;
    tmo      = (lat == 0) || (lat > TMO);
    e.is_mem = mw;
    e.addr   = mw ? ma : ia;
    e.we     = mw ? we : 1'b0;
    e.wdata  = mw ? wd : 32'd0;
    e.err    = tmo;
    e.busy   = tmo ? TMO : lat;
    e.rdata  = (tmo || (mw && we)) ? 32'd0 : rd;
    q.push_back(e);
    @(posedge clk); #1;
    if (drop) begin
      if (mw) mem_req = 1'b0;
      else    if_req  = 1'b0;
    end
    for (int unsigned k = 1; k <= TMO; k++) begin
      ram_ready = (k == lat);
      ram_rdata = (k == lat) ? rd : $urandom;
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_we    = $urandom_range(0, 1);
      @(posedge clk); #1;
      if (k == lat) break;
    end
    // DONE cycle: ram_ready noise here and in IDLE must be ignored
    ram_ready = $urandom_range(0, 1);
    ram_rdata = $urandom;
    @(posedge clk); #1;
    chk("done_seen", q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; ram_ready = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch
    txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 1, 0, 32'hDEADBEEF);
    if_req = 0;
    // Store held for 3 BUSY cycles
    txn(0, 1, 1, 32'h0, 32'h40, 32'h1234, 3, 0, 32'hCAFEF00D);
    mem_req = 0;
    @(posedge clk); #1;
    // Contention: MEM x4, IF, MEM x4, IF
    mem_grants_in_row = 0;
    for (int i = 0; i < 10; i++) begin
      txn(1, 1, $urandom_range(0, 1), $urandom, $urandom, $urandom, 1, 0, $urandom);
      if (i == 4 || i == 9) chk("contention_if_turn", {31'd0, q.size() == 0 && mem_grants_in_row == 4}, 32'd1);
      mem_grants_in_row = (m_streak == 0) ? 0 : mem_grants_in_row + 1;
    end
    if_req = 0; mem_req = 0;
    @(posedge clk); #1;
    // Timeout, then a clean access clearing err
    txn(0, 1, 0, 32'h0, 32'h80, 32'h0, 0, 0, 32'h11111111);
    txn(0, 1, 0, 32'h0, 32'h84, 32'h0, 2, 0, 32'h22222222);
    mem_req = 0;
    // Reset on the 2nd BUSY cycle
    txn_reset();
    // Request dropped in the 1st BUSY cycle
    txn(1, 0, 0, 32'h200, 32'h0, 32'h0, 1, 1, 32'h55AA55AA);
    @(posedge clk); #1;
    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom, $urandom, $urandom,
          ($urandom_range(0, 9) == 0) ? $urandom_range(0, TMO + 2) : $urandom_range(1, 4),
          ($urandom_range(0, 4) == 0), $urandom);
    end
    if_req = 0; mem_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic txn_reset();
    exp_t e;
    if_req = 0; mem_req = 1; mem_we = 1; mem_addr = 32'h300; mem_wdata = 32'h9999;
    m_streak = 0;
    e.is_mem = 1; e.addr = 32'h300; e.we = 1; e.wdata = 32'h9999;
    e.rdata = '0; e.err = 0; e.busy = 2;
    q.push_back(e);
    ram_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    mem_req = 0;
    @(posedge clk); #1;
    chk("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("mid_rst_ram_addr", ram_addr, 32'd0);
    chk("mid_rst_ram_wdata", ram_wdata, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    reset = 1'b0;
    m_streak = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

endmodule
